// File: rtl/ula_unit.sv
// ---------------------------------------------------------------------------
// ula_unit -- 32-bit integer ALU for the RISC-V datapath.
//
// One operation per cycle, selected by UlaOp. The combinational result and
// flags are captured in output registers on each rising clock edge, giving a
// fixed one-cycle latency with no handshake.
//
// Ports:
//   clk       system clock, all state updates on the rising edge
//   rst       synchronous, active-high reset (S=0, Zero=1, Carry=0, Overflow=0)
//   A, B      operands
//   UlaOp     operation select (see op constants below; others are reserved)
//   S         registered result
//   Zero      registered, 1 when the captured result is 0
//   Carry     registered, carry-out for ADD, no-borrow for SUB, else 0
//   Overflow  registered, signed overflow for ADD/SUB, else 0
// ---------------------------------------------------------------------------
module ula_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       UlaOp,
  output logic [WIDTH-1:0] S,
  output logic             Zero,
  output logic             Carry,
  output logic             Overflow
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;
  localparam logic [3:0] OP_NOR  = 4'b1100;

  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] s_next;
  logic             zero_next;
  logic             carry_next;
  logic             overflow_next;

  // Shared adders: bit WIDTH of each is the carry-out. Subtraction is done as
  // A + ~B + 1, so its carry-out is 1 exactly when no borrow occurs (A >= B).
  assign add_full = {1'b0, A} + {1'b0, B};
  assign sub_full = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};

  // Only the low bits of B select the shift distance; upper bits are ignored.
  assign shamt = B[SHW-1:0];

  always_comb begin
    s_next        = '0;
    carry_next    = 1'b0;
    overflow_next = 1'b0;
    case (UlaOp)
      OP_AND: s_next = A & B;
      OP_OR:  s_next = A | B;
      OP_XOR: s_next = A ^ B;
      OP_NOR: s_next = ~(A | B);
      OP_ADD: begin
        s_next        = add_full[WIDTH-1:0];
        carry_next    = add_full[WIDTH];
        // Like-signed operands producing a result of the other sign.
        overflow_next = (A[WIDTH-1] == B[WIDTH-1]) &&
                        (add_full[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        s_next        = sub_full[WIDTH-1:0];
        carry_next    = sub_full[WIDTH];
        // Unlike-signed operands where the result sign departs from A.
        overflow_next = (A[WIDTH-1] != B[WIDTH-1]) &&
                        (sub_full[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SLL: s_next = A << shamt;
      OP_SRL: s_next = A >> shamt;
      OP_SRA: s_next = $unsigned($signed(A) >>> shamt);
      // Direct signed compare rather than the sign of A-B, so the answer
      // stays right when the subtraction overflows.
      OP_SLT:  s_next = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: s_next = {{(WIDTH-1){1'b0}}, (A < B)};
      default: begin
        // Reserved encodings leave everything at zero.
        s_next        = '0;
        carry_next    = 1'b0;
        overflow_next = 1'b0;
      end
    endcase
  end

  assign zero_next = (s_next == '0);

  // Reset assigns constants only, so undefined operands during reset can
  // never reach the registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      S        <= '0;
      Zero     <= 1'b1;
      Carry    <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      S        <= s_next;
      Zero     <= zero_next;
      Carry    <= carry_next;
      Overflow <= overflow_next;
    end
  end

endmodule

// File: tb/tb_ula_unit.sv
// ---------------------------------------------------------------------------
// tb_ula_unit -- self-checking bench for ula_unit.
//
// A behavioural model predicts every registered output from the inputs seen
// at each rising edge, using wide integer arithmetic. A single compare process
// checks the DUT against the model on every falling edge and, where the
// stimulus attached one, against a hand-computed literal expectation too.
// ---------------------------------------------------------------------------
module tb_ula_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  op;
  logic [31:0] s;
  logic        zero;
  logic        carry;
  logic        overflow;

  always #5 clk = ~clk;

  ula_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .A        (a),
    .B        (b),
    .UlaOp    (op),
    .S        (s),
    .Zero     (zero),
    .Carry    (carry),
    .Overflow (overflow)
  );

  // Literal expectation travelling with the current stimulus.
  logic        lit_en;
  logic [31:0] lit_s;
  logic        lit_z, lit_c, lit_v;
  string       lit_name;

  // Expectations for the outputs after the most recent rising edge.
  logic        exp_valid = 1'b0;
  logic [31:0] exp_s;
  logic        exp_z, exp_c, exp_v;
  logic [3:0]  exp_op;
  logic        pend_en = 1'b0;
  logic [31:0] pend_s;
  logic        pend_z, pend_c, pend_v;
  string       pend_name;

  int n_vec = 0;
  int n_bad = 0;

  // Behavioural model: plain 64-bit arithmetic on the operands.
  function automatic void model(input logic [3:0] o, input logic [31:0] x,
                                input logic [31:0] y, output logic [31:0] rs,
                                output logic rc, output logic rv);
    longint sx, sy, wide;
    longint unsigned usum;
    int sh;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    sh = int'(y % 32);
    rs = 32'd0;
    rc = 1'b0;
    rv = 1'b0;
    case (o)
      4'd0:  rs = x & y;
      4'd1:  rs = x | y;
      4'd2: begin
        usum = longint'(x) + longint'(y);
        rs   = usum[31:0];
        rc   = (usum >= 64'd4294967296);
        wide = sx + sy;
        rv   = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
      4'd3:  rs = x ^ y;
      4'd4:  rs = x << sh;
      4'd5:  rs = x >> sh;
      4'd6: begin
        rs   = x - y;
        rc   = (x >= y);
        wide = sx - sy;
        rv   = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
      4'd7:  rs = (sx < sy) ? 32'd1 : 32'd0;
      4'd8:  rs = (x < y) ? 32'd1 : 32'd0;
      4'd9:  rs = x[31] ? ~((~x) >> sh) : (x >> sh);
      4'd12: rs = ~(x | y);
      default: rs = 32'd0;
    endcase
  endfunction

  // Model process: predict what the DUT registers at this edge.
  always @(posedge clk) begin
    if (rst) begin
      exp_s = 32'd0;
      exp_c = 1'b0;
      exp_v = 1'b0;
    end else begin
      model(op, a, b, exp_s, exp_c, exp_v);
    end
    exp_z     = (exp_s == 32'd0);
    exp_op    = rst ? 4'hx : op;
    exp_valid = 1'b1;
    pend_en   = lit_en;
    pend_s    = lit_s;
    pend_z    = lit_z;
    pend_c    = lit_c;
    pend_v    = lit_v;
    pend_name = lit_name;
  end

  // Compare process: sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (exp_valid) begin
      n_vec++;
      if (s !== exp_s || zero !== exp_z || carry !== exp_c || overflow !== exp_v) begin
        n_bad++;
        $display("FAIL model op=%b got S=%h Z=%b C=%b V=%b expected S=%h Z=%b C=%b V=%b",
                 exp_op, s, zero, carry, overflow, exp_s, exp_z, exp_c, exp_v);
      end
      if (pend_en) begin
        n_vec++;
        if (s !== pend_s || zero !== pend_z || carry !== pend_c || overflow !== pend_v) begin
          n_bad++;
          $display("FAIL %s got S=%h Z=%b C=%b V=%b expected S=%h Z=%b C=%b V=%b",
                   pend_name, s, zero, carry, overflow, pend_s, pend_z, pend_c, pend_v);
        end
      end
    end
  end

  // Drive one cycle of stimulus, optionally with a literal expectation.
  task automatic issue(input logic r, input logic [3:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic le, input logic [31:0] ls,
                       input logic lz, input logic lc, input logic lv, input string nm);
    rst      = r;
    op       = o;
    a        = x;
    b        = y;
    lit_en   = le;
    lit_s    = ls;
    lit_z    = lz;
    lit_c    = lc;
    lit_v    = lv;
    lit_name = nm;
    @(negedge clk);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    // Reset with undefined operands.
    issue(1'b1, 4'bx, 32'hx, 32'hx, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0, "reset1");
    issue(1'b1, 4'bx, 32'hx, 32'hx, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0, "reset2");

    // Basic ops with A=20, B=12.
    issue(1'b0, 4'b0000, 32'd20, 32'd12, 1'b1, 32'd4,  1'b0, 1'b0, 1'b0, "and");
    issue(1'b0, 4'b0001, 32'd20, 32'd12, 1'b1, 32'd28, 1'b0, 1'b0, 1'b0, "or");
    issue(1'b0, 4'b0010, 32'd20, 32'd12, 1'b1, 32'd32, 1'b0, 1'b0, 1'b0, "add");
    issue(1'b0, 4'b0110, 32'd20, 32'd12, 1'b1, 32'd8,  1'b0, 1'b1, 1'b0, "sub");
    issue(1'b0, 4'b1111, 32'd20, 32'd12, 1'b1, 32'd0,  1'b1, 1'b0, 1'b0, "reserved");
    issue(1'b0, 4'b0011, 32'd20, 32'd12, 1'b1, 32'd24, 1'b0, 1'b0, 1'b0, "xor");
    issue(1'b0, 4'b1100, 32'd20, 32'd12, 1'b1, 32'hFFFF_FFE3, 1'b0, 1'b0, 1'b0, "nor");

    // Arithmetic flags.
    issue(1'b0, 4'b0010, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, "add_carry");
    issue(1'b0, 4'b0010, 32'h7FFF_FFFF, 32'd1, 1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b1, "add_ovf");
    issue(1'b0, 4'b0110, 32'd12, 32'd20, 1'b1, 32'hFFFF_FFF8, 1'b0, 1'b0, 1'b0, "sub_borrow");
    issue(1'b0, 4'b0110, 32'd5,  32'd5,  1'b1, 32'h0, 1'b1, 1'b1, 1'b0, "sub_equal");

    // Shifts.
    issue(1'b0, 4'b0100, 32'd1, 32'd31, 1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b0, "sll31");
    issue(1'b0, 4'b0100, 32'd1, 32'h21, 1'b1, 32'd2, 1'b0, 1'b0, 1'b0, "sll_mask");
    issue(1'b0, 4'b0101, 32'h8000_0000, 32'd4, 1'b1, 32'h0800_0000, 1'b0, 1'b0, 1'b0, "srl4");
    issue(1'b0, 4'b1001, 32'h8000_0000, 32'd4, 1'b1, 32'hF800_0000, 1'b0, 1'b0, 1'b0, "sra4");
    issue(1'b0, 4'b0101, 32'h1234_5678, 32'h40, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0, "srl0");

    // Compares.
    issue(1'b0, 4'b0111, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'd1, 1'b0, 1'b0, 1'b0, "slt_neg");
    issue(1'b0, 4'b1000, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'd0, 1'b1, 1'b0, 1'b0, "sltu");
    issue(1'b0, 4'b0111, 32'h8000_0000, 32'd1, 1'b1, 32'd1, 1'b0, 1'b0, 1'b0, "slt_ovf");
    issue(1'b0, 4'b0111, 32'd20, 32'd12, 1'b1, 32'd0, 1'b1, 1'b0, 1'b0, "slt_pos");

    // Back-to-back ADD then SUB, then reset colliding with an ADD.
    issue(1'b0, 4'b0010, 32'd100, 32'd23, 1'b1, 32'd123, 1'b0, 1'b0, 1'b0, "b2b_add");
    issue(1'b0, 4'b0110, 32'd100, 32'd23, 1'b1, 32'd77,  1'b0, 1'b1, 1'b0, "b2b_sub");
    issue(1'b1, 4'b0010, 32'd3, 32'd4, 1'b1, 32'd0, 1'b1, 1'b0, 1'b0, "rst_prio");
    issue(1'b0, 4'b0010, 32'd3, 32'd4, 1'b1, 32'd7, 1'b0, 1'b0, 1'b0, "after_rst");

    // Randomized traffic with occasional resets, checked against the model.
    for (int i = 0; i < 400; i++) begin
      issue(($urandom_range(0, 39) == 0), 4'($urandom_range(0, 15)), pick(), pick(),
            1'b0, 32'h0, 1'b0, 1'b0, 1'b0, "rand");
    end

    // Let the final issued operation be compared before reporting.
    issue(1'b0, 4'b0000, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, "idle");
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
